// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer
//
// Fetch stage between the PC stage and decode. Each accepted PC/PCPlus4 pair
// is sent to instruction memory and takes one slot in a small circular buffer.
// Memory responses come back in order and fill the oldest unfilled entry.
// The head entry is offered to decode once its word has arrived.
//
// A redirect (flush) invalidates every entry. It also records how many
// responses are still owed for the killed requests (drop_cnt). Those responses
// are then swallowed as they arrive. Slots stay reserved until they do, so
// the buffer can never hold more than DEPTH outstanding items.
//
// Parameters
//   DEPTH     total slots (live entries + pending drops), power of two, >= 2
//   NOP_WORD  word presented for a misaligned fetch
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   PC, PCPlus4, pc_valid          fetch request from the PC stage
//   pc_ready                       fetch accepted this cycle
//   flush                          redirect, kills everything older
//   imem_req_valid/ready, imem_addr       memory request channel
//   imem_rsp_valid, imem_rsp_data         in-order memory response
//   instr_valid, instr_ready              decode handshake
//   InstrD, PCD, PCPlus4D                 head entry contents
//   misaligned                            head entry came from a misaligned PC
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to stop misaligned PCs
// from reaching memory. Such a fetch is instead pushed as an already-filled
// NOP_WORD entry with the misaligned flag set. When the macro is undefined,
// misaligned is tied to 0.
// -----------------------------------------------------------------------------
module instr_fetch_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic [31:0] PCPlus4,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        misaligned
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Pointers and counters
    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] live_cnt_reg, drop_cnt_reg;
    logic [PTR_W-1:0] head_next, tail_next;
    logic [CNT_W-1:0] live_cnt_next, drop_cnt_next;

    // Entry storage
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] pcp4_mem  [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic        live_reg  [DEPTH];
    logic        filled_reg[DEPTH];

    // Datapath control
    logic [CNT_W:0]   occ;
    logic             credit;
    logic             mis_fetch;
    logic             push, pop;
    logic             rsp_take, rsp_drop, fill_en;
    logic             fill_hit;
    logic [PTR_W-1:0] fill_idx, scan_idx;
    logic [CNT_W-1:0] unfilled_cnt, drop_after;

    // Credit comes from registered state only. A pop this cycle frees its
    // slot for the next cycle, not for a push in the same cycle.
    assign occ    = {1'b0, live_cnt_reg} + {1'b0, drop_cnt_reg};
    assign credit = (occ < (CNT_W + 1)'(DEPTH));

    assign imem_addr      = PC;
    assign imem_req_valid = pc_valid & credit & ~flush & ~mis_fetch;
    // A misaligned fetch never goes to memory, so it does not wait on imem_req_ready.
    assign pc_ready       = pc_valid & credit & ~flush & (mis_fetch | imem_req_ready);
    assign push           = pc_ready;

    assign instr_valid = live_reg[head_reg] & filled_reg[head_reg];
    assign pop         = instr_valid & instr_ready & ~flush;
    assign InstrD      = instr_mem[head_reg];
    assign PCD         = pc_mem[head_reg];
    assign PCPlus4D    = pcp4_mem[head_reg];

    // Scan from the head for the oldest live entry still waiting on memory.
    // Misaligned entries are pushed pre-filled, so unfilled entries need not
    // be contiguous and a plain fill pointer would not work.
    always_comb begin
        fill_hit     = 1'b0;
        fill_idx     = head_reg;
        scan_idx     = head_reg;
        unfilled_cnt = '0;
        for (int off = 0; off < DEPTH; off++) begin
            scan_idx = head_reg + PTR_W'(off);
            if (live_reg[scan_idx] && !filled_reg[scan_idx]) begin
                unfilled_cnt = unfilled_cnt + CNT_W'(1);
                if (!fill_hit) begin
                    fill_hit = 1'b1;
                    fill_idx = scan_idx;
                end
            end
        end
    end

    assign rsp_take   = imem_rsp_valid & (drop_cnt_reg == '0) & fill_hit;
    assign rsp_drop   = imem_rsp_valid & (drop_cnt_reg != '0);
    assign fill_en    = rsp_take & ~flush;
    assign drop_after = rsp_drop ? (drop_cnt_reg - CNT_W'(1)) : drop_cnt_reg;

    always_comb begin
        head_next     = head_reg;
        tail_next     = tail_reg;
        live_cnt_next = live_cnt_reg;
        drop_cnt_next = drop_after;
        if (flush) begin
            // Each unfilled entry still owes a response. A response taken this
            // cycle is already accounted for, so it is not owed again.
            drop_cnt_next = unfilled_cnt - CNT_W'(rsp_take) + drop_after;
            head_next     = tail_reg;
            live_cnt_next = '0;
        end else begin
            if (push) tail_next = tail_reg + PTR_W'(1);
            if (pop)  head_next = head_reg + PTR_W'(1);
            live_cnt_next = live_cnt_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            live_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            live_cnt_reg <= live_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Per-entry state. Within one cycle, pop clears, fill writes and push
    // writes. A push never targets an entry that is being popped or filled
    // in the same cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    pc_mem[gi]     <= '0;
                    pcp4_mem[gi]   <= '0;
                    instr_mem[gi]  <= '0;
                    live_reg[gi]   <= 1'b0;
                    filled_reg[gi] <= 1'b0;
                end else if (flush) begin
                    live_reg[gi]   <= 1'b0;
                    filled_reg[gi] <= 1'b0;
                end else begin
                    if (pop && head_reg == PTR_W'(gi)) begin
                        live_reg[gi]   <= 1'b0;
                        filled_reg[gi] <= 1'b0;
                    end
                    if (fill_en && fill_idx == PTR_W'(gi)) begin
                        instr_mem[gi]  <= imem_rsp_data;
                        filled_reg[gi] <= 1'b1;
                    end
                    if (push && tail_reg == PTR_W'(gi)) begin
                        pc_mem[gi]     <= PC;
                        pcp4_mem[gi]   <= PCPlus4;
                        // For a normal fetch the fill overwrites this word.
                        // For a misaligned fetch it is the final word.
                        instr_mem[gi]  <= NOP_WORD;
                        live_reg[gi]   <= 1'b1;
                        filled_reg[gi] <= mis_fetch;
                    end
                end
            end
        end
    endgenerate

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_reg [DEPTH];

    assign mis_fetch  = (PC[1:0] != 2'b00);
    assign misaligned = live_reg[head_reg] & mis_reg[head_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_mis
            always_ff @(posedge clk) begin
                if (rst) begin
                    mis_reg[gi] <= 1'b0;
                end else if (!flush && push && tail_reg == PTR_W'(gi)) begin
                    mis_reg[gi] <= mis_fetch;
                end
            end
        end
    endgenerate
`else
    assign mis_fetch  = 1'b0;
    assign misaligned = 1'b0;
`endif

    // A response with nothing waiting for it and nothing to drop means the
    // memory broke the in-order protocol. The response is ignored.
    orphan_rsp_chk: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && drop_cnt_reg == '0 && !fill_hit));

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC, PCPlus4;
    logic        pc_valid, pc_ready, flush;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        misaligned;

    int vectors    = 0;
    int miscompares = 0;

    instr_fetch_buffer #(.DEPTH(2), .NOP_WORD(32'h00000013)) dut (
        .clk(clk), .rst(rst),
        .PC(PC), .PCPlus4(PCPlus4), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc);
        pc_valid = v;
        PC       = pc;
        PCPlus4  = pc + 32'd4;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d);
        imem_rsp_valid = v;
        imem_rsp_data  = d;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b0;
        fetch(1'b0, 32'h0); rsp(1'b0, 32'h0);
        tick(); tick();
        #1;
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_pc_ready", pc_ready, 1'b0);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_misaligned", misaligned, 1'b0);
        chk("rst_InstrD", InstrD, 32'h0);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick();

        // ---- sequential stream 0x0..0xC, 1-cycle memory ----
        fetch(1'b1, 32'h0); #1;
        chk("s1_pc_ready", pc_ready, 1'b1);
        chk("s1_addr", imem_addr, 32'h0);
        chk("s1_ivalid", instr_valid, 1'b0);
        tick();
        fetch(1'b1, 32'h4); rsp(1'b1, 32'h00100093); #1;
        chk("s2_pc_ready", pc_ready, 1'b1);
        chk("s2_ivalid", instr_valid, 1'b0);
        tick();
        fetch(1'b1, 32'h8); rsp(1'b1, 32'h00200113); #1;
        chk("s3_full_pc_ready", pc_ready, 1'b0);
        chk("s3_InstrD", InstrD, 32'h00100093);
        chk("s3_PCD", PCD, 32'h0);
        chk("s3_PCPlus4D", PCPlus4D, 32'h4);
        tick();
        rsp(1'b0, 32'h0); #1;
        chk("s4_pc_ready", pc_ready, 1'b1);
        chk("s4_InstrD", InstrD, 32'h00200113);
        chk("s4_PCD", PCD, 32'h4);
        chk("s4_PCPlus4D", PCPlus4D, 32'h8);
        tick();
        fetch(1'b1, 32'hC); rsp(1'b1, 32'h00300193); #1;
        chk("s5_pc_ready", pc_ready, 1'b1);
        chk("s5_ivalid", instr_valid, 1'b0);
        tick();
        fetch(1'b0, 32'h0); rsp(1'b1, 32'h00400213); #1;
        chk("s6_InstrD", InstrD, 32'h00300193);
        chk("s6_PCD", PCD, 32'h8);
        tick();
        rsp(1'b0, 32'h0); #1;
        chk("s7_InstrD", InstrD, 32'h00400213);
        chk("s7_PCD", PCD, 32'hC);
        chk("s7_PCPlus4D", PCPlus4D, 32'h10);
        tick();
        #1 chk("s8_ivalid", instr_valid, 1'b0);

        // ---- decode stall with DEPTH=2 ----
        instr_ready = 1'b0;
        fetch(1'b1, 32'h20); #1;
        chk("d1_pc_ready", pc_ready, 1'b1);
        tick();
        fetch(1'b1, 32'h24); rsp(1'b1, 32'hAAAA0001); #1;
        chk("d2_pc_ready", pc_ready, 1'b1);
        tick();
        fetch(1'b1, 32'h28); rsp(1'b1, 32'hAAAA0002); #1;
        chk("d3_pc_ready", pc_ready, 1'b0);
        chk("d3_req_valid", imem_req_valid, 1'b0);
        chk("d3_PCD", PCD, 32'h20);
        tick();
        rsp(1'b0, 32'h0); #1;
        chk("d4_pc_ready", pc_ready, 1'b0);
        chk("d4_InstrD", InstrD, 32'hAAAA0001);
        tick();
        instr_ready = 1'b1; #1;
        chk("d5_InstrD", InstrD, 32'hAAAA0001);
        chk("d5_pc_ready", pc_ready, 1'b0);
        tick();
        #1;
        chk("d6_InstrD", InstrD, 32'hAAAA0002);
        chk("d6_PCD", PCD, 32'h24);
        chk("d6_pc_ready", pc_ready, 1'b1);
        tick();
        fetch(1'b0, 32'h0); rsp(1'b1, 32'hAAAA0003); #1;
        chk("d7_ivalid", instr_valid, 1'b0);
        tick();
        rsp(1'b0, 32'h0); #1;
        chk("d8_InstrD", InstrD, 32'hAAAA0003);
        chk("d8_PCD", PCD, 32'h28);
        chk("d8_PCPlus4D", PCPlus4D, 32'h2C);
        tick();

        // ---- memory backpressure ----
        imem_req_ready = 1'b0;
        fetch(1'b1, 32'h40);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_pc_ready", pc_ready, 1'b0);
            chk("bp_req_valid", imem_req_valid, 1'b1);
            tick();
        end
        imem_req_ready = 1'b1;
        fetch(1'b1, 32'h44); #1;
        chk("bp_resume_pc_ready", pc_ready, 1'b1);
        tick();
        fetch(1'b0, 32'h0); rsp(1'b1, 32'hBBBB0044); #1;
        chk("bp_ivalid_before_fill", instr_valid, 1'b0);
        tick();
        rsp(1'b0, 32'h0); #1;
        chk("bp_PCD", PCD, 32'h44);
        chk("bp_InstrD", InstrD, 32'hBBBB0044);
        tick();

        // ---- flush with two requests in flight, 3-cycle memory ----
        fetch(1'b1, 32'h60); #1;
        chk("f1_pc_ready", pc_ready, 1'b1);
        tick();
        fetch(1'b1, 32'h64); #1;
        chk("f2_pc_ready", pc_ready, 1'b1);
        tick();
        fetch(1'b0, 32'h0); flush = 1'b1; #1;
        chk("f3_req_valid", imem_req_valid, 1'b0);
        tick();
        flush = 1'b0; fetch(1'b1, 32'h100); rsp(1'b1, 32'hDEAD0060); #1;
        chk("f4_two_drops_pc_ready", pc_ready, 1'b0);
        chk("f4_ivalid", instr_valid, 1'b0);
        tick();
        rsp(1'b1, 32'hDEAD0064); #1;
        chk("f5_one_drop_pc_ready", pc_ready, 1'b1);
        chk("f5_ivalid", instr_valid, 1'b0);
        tick();
        fetch(1'b0, 32'h0); rsp(1'b1, 32'hCCCC0100); #1;
        chk("f6_ivalid", instr_valid, 1'b0);
        tick();
        rsp(1'b0, 32'h0); #1;
        chk("f7_ivalid", instr_valid, 1'b1);
        chk("f7_InstrD", InstrD, 32'hCCCC0100);
        chk("f7_PCD", PCD, 32'h100);
        chk("f7_PCPlus4D", PCPlus4D, 32'h104);
        tick();

        // ---- flush coinciding with a response ----
        fetch(1'b1, 32'h200); tick();
        fetch(1'b1, 32'h204); tick();
        fetch(1'b0, 32'h0); rsp(1'b1, 32'hDEAD0200); flush = 1'b1; #1;
        chk("g3_ivalid", instr_valid, 1'b0);
        tick();
        flush = 1'b0; rsp(1'b0, 32'h0); fetch(1'b1, 32'h300); #1;
        chk("g4_ivalid_after_flush", instr_valid, 1'b0);
        chk("g4_one_drop_pc_ready", pc_ready, 1'b1);
        tick();
        fetch(1'b0, 32'h0); rsp(1'b1, 32'hDEAD0204); #1;
        chk("g5_ivalid", instr_valid, 1'b0);
        tick();
        rsp(1'b1, 32'hEEEE0300); #1;
        chk("g6_ivalid", instr_valid, 1'b0);
        tick();
        rsp(1'b0, 32'h0); #1;
        chk("g7_InstrD", InstrD, 32'hEEEE0300);
        chk("g7_PCD", PCD, 32'h300);
        tick();

        // ---- misaligned PC ----
`ifdef FETCH_MISALIGN_CHECK_EN
        imem_req_ready = 1'b0;
        fetch(1'b1, 32'h6); #1;
        chk("m1_req_valid", imem_req_valid, 1'b0);
        chk("m1_pc_ready", pc_ready, 1'b1);
        tick();
        fetch(1'b0, 32'h0); imem_req_ready = 1'b1; #1;
        chk("m2_ivalid", instr_valid, 1'b1);
        chk("m2_InstrD", InstrD, 32'h00000013);
        chk("m2_misaligned", misaligned, 1'b1);
        chk("m2_PCD", PCD, 32'h6);
        tick();
`else
        fetch(1'b1, 32'h6); #1;
        chk("m1_req_valid", imem_req_valid, 1'b1);
        chk("m1_addr", imem_addr, 32'h6);
        tick();
        fetch(1'b0, 32'h0); rsp(1'b1, 32'h12345678); tick();
        rsp(1'b0, 32'h0); #1;
        chk("m3_InstrD", InstrD, 32'h12345678);
        chk("m3_misaligned", misaligned, 1'b0);
        chk("m3_PCD", PCD, 32'h6);
        tick();
`endif

        // ---- reset mid-operation ----
        fetch(1'b1, 32'h400); tick();
        fetch(1'b0, 32'h0); rsp(1'b1, 32'h0BAD0400); rst = 1'b1; tick();
        rsp(1'b0, 32'h0); tick();
        rst = 1'b0; #1;
        chk("r_ivalid", instr_valid, 1'b0);
        chk("r_PCD", PCD, 32'h0);
        chk("r_InstrD", InstrD, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
